// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter and write sequencer owning the single write path of a shared DW-bit register.
// Optional sticky grant lock is enabled by defining ARB_LOCK_EN.
module reg_share_arbiter #(
  parameter  int SW   = 2,
  parameter  int DW   = 8,
  localparam int NREQ = 2 ** SW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] wdata,
`ifdef ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [NREQ-1:0]    gnt,
  output logic [DW-1:0]      q,
  output logic               q_vld,
  output logic [SW-1:0]      q_src
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GNT,
    S_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [DW-1:0]     q_q, q_d;
  logic              q_vld_q, q_vld_d;
  logic [SW-1:0]     q_src_q, q_src_d;
  logic [SW-1:0]     ptr_q, ptr_d;
  logic [SW-1:0]     win_q, win_d;

  logic              rr_found;
  logic [SW-1:0]     rr_win;
  logic [SW-1:0]     scan_idx;

  logic              keep_lock;
`ifdef ARB_LOCK_EN
  logic              lock_flag_q, lock_flag_d;
  assign keep_lock = lock_flag_q && req[ptr_q];
`else
  assign keep_lock = 1'b0;
`endif

  // Scan ptr+1, ptr+2, ... wrapping naturally in SW bits; the last slot checked is ptr itself.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    rr_found = 1'b0;
    rr_win   = ptr_q;
    scan_idx = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = ptr_q + SW'(k);
      if (!rr_found && req[scan_idx]) begin
        rr_found = 1'b1;
        rr_win   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    q_d     = q_q;
    q_vld_d = q_vld_q;
    q_src_d = q_src_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
`ifdef ARB_LOCK_EN
    lock_flag_d = lock_flag_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (keep_lock) begin
          win_d   = ptr_q;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << ptr_q;
          state_d = S_GNT;
        end else begin
`ifdef ARB_LOCK_EN
          lock_flag_d = 1'b0;
`endif
          if (rr_found) begin
            win_d   = rr_win;
            gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << rr_win;
            state_d = S_GNT;
          end
        end
      end
      S_GNT: begin
        // The write completes regardless of req; wdata is sampled on this edge.
        q_d     = wdata[win_q*DW +: DW];
        q_src_d = win_q;
        ptr_d   = win_q;
        gnt_d   = '0;
        q_vld_d = 1'b1;
`ifdef ARB_LOCK_EN
        lock_flag_d = lock;
`endif
        state_d = S_HOLD;
      end
      S_HOLD: begin
        q_vld_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        q_vld_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      q_q     <= '0;
      q_vld_q <= 1'b0;
      q_src_q <= '0;
      ptr_q   <= SW'(NREQ - 1);
      win_q   <= '0;
`ifdef ARB_LOCK_EN
      lock_flag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      q_vld_q <= q_vld_d;
      q_src_q <= q_src_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
`ifdef ARB_LOCK_EN
      lock_flag_q <= lock_flag_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign q     = q_q;
  assign q_vld = q_vld_q;
  assign q_src = q_src_q;

endmodule
